// File: rtl/rv32_mc_sequencer.sv
// rv32_mc_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the
// RV32I R-type datapath. Owns the PC and instruction register, fetches over a
// req/ack port, decodes the R-type ALU encoding and retires one instruction per
// pass. Illegal instructions and fetch timeouts park the block in a sticky FAULT.
module rv32_mc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clr_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic [4:0]  rf_wa,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        dec_legal;
  logic [3:0]  dec_code;

  // Decode the latched instruction into a legality flag and an ALU opcode
  always_comb begin
    dec_legal = 1'b0;
    dec_code  = 4'd0;
    if (ir_q[6:0] == 7'b0110011) begin
      dec_legal = 1'b1;
      case ({ir_q[31:25], ir_q[14:12]})
        10'b0000000_000: dec_code = 4'd0;
        10'b0100000_000: dec_code = 4'd1;
        10'b0000000_001: dec_code = 4'd2;
        10'b0000000_101: dec_code = 4'd3;
        10'b0100000_101: dec_code = 4'd4;
        10'b0000000_010: dec_code = 4'd5;
        10'b0000000_011: dec_code = 4'd6;
        10'b0000000_100: dec_code = 4'd7;
        10'b0000000_110: dec_code = 4'd8;
        10'b0000000_111: dec_code = 4'd9;
        default:         dec_legal = 1'b0;
      endcase
    end
  end

  // State and datapath registers; reset returns everything to the idle image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      retired_q    <= 32'd0;
      alu_ctrl_q   <= 4'd0;
      fault_code_q <= 2'b00;
      tmo_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      alu_ctrl_q   <= alu_ctrl_d;
      fault_code_q <= fault_code_d;
      tmo_q        <= tmo_d;
    end
  end

  // Next-state and register updates; the timeout counter is zeroed whenever FETCH is entered
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    alu_ctrl_d   = alu_ctrl_q;
    fault_code_d = fault_code_q;
    tmo_d        = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          tmo_d   = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b01;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          alu_ctrl_d = dec_code;
          state_d    = S_EXEC;
        end else begin
          state_d      = S_FAULT;
          fault_code_d = 2'b10;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        if (run) begin
          state_d = S_FETCH;
          tmo_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (clr_fault) begin
          state_d      = S_IDLE;
          fault_code_d = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State-decoded strobes; writes to x0 are suppressed but the instruction still retires
  always_comb begin
    imem_req = (state_q == S_FETCH);
    busy     = (state_q == S_FETCH) || (state_q == S_DECODE) ||
               (state_q == S_EXEC)  || (state_q == S_WB);
    fault    = (state_q == S_FAULT);
    rf_we    = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rf_ra1     = ir_q[19:15];
  assign rf_ra2     = ir_q[24:20];
  assign rf_wa      = ir_q[11:7];
  assign fault_code = fault_code_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_rv32_mc_sequencer.sv
// tb_rv32_mc_sequencer: table-driven plus randomized bench for the sequencer.
// A second instance with RESET_PC = FFFF_FFFC shares every input so its PC
// must always equal the main PC offset by -4, which exercises the wrap.
module tb_rv32_mc_sequencer;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        clr_fault;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, rf_we, busy, fault;
  logic [31:0] imem_addr, ir, pc, retired;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [1:0]  fault_code;

  logic        imem_req_w, rf_we_w, busy_w, fault_w;
  logic [31:0] imem_addr_w, ir_w, pc_w, retired_w;
  logic [3:0]  alu_ctrl_w;
  logic [4:0]  rf_ra1_w, rf_ra2_w, rf_wa_w;
  logic [1:0]  fault_code_w;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  typedef struct {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
  } op_t;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    bit          legal;
    logic [3:0]  code;
    bit          drop_run;
  } vec_t;

  op_t  ops  [10];
  vec_t vecs [14];

  rv32_mc_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .clr_fault(clr_fault),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .alu_ctrl(alu_ctrl),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
    .pc(pc), .busy(busy), .fault(fault), .fault_code(fault_code),
    .retired(retired)
  );

  rv32_mc_sequencer #(.RESET_PC(WRAP_PC), .FETCH_TIMEOUT(16)) dut_w (
    .clk(clk), .reset(reset), .run(run), .clr_fault(clr_fault),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir_w), .alu_ctrl(alu_ctrl_w),
    .rf_ra1(rf_ra1_w), .rf_ra2(rf_ra2_w), .rf_wa(rf_wa_w), .rf_we(rf_we_w),
    .pc(pc_w), .busy(busy_w), .fault(fault_w), .fault_code(fault_code_w),
    .retired(retired_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic a, input logic [31:0] d);
    run        = r;
    clr_fault  = c;
    imem_ack   = a;
    imem_rdata = d;
  endtask

  // Reference decode: legal iff R-type opcode and the funct pair appears in the op list
  function automatic void refDecode(input logic [31:0] instr, output bit legal, output logic [3:0] code);
    legal = 1'b0;
    code  = 4'd0;
    if (instr[6:0] == 7'b0110011) begin
      foreach (ops[i]) begin
        if (ops[i].f7 == instr[31:25] && ops[i].f3 == instr[14:12]) begin
          legal = 1'b1;
          code  = ops[i].code;
        end
      end
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"}, pc, 32'h0);
    checkOutput({tag, "_pc_w"}, pc_w, WRAP_PC);
    checkOutput({tag, "_ir"}, ir, 32'h0);
    checkOutput({tag, "_alu"}, {28'd0, alu_ctrl}, 32'h0);
    checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'h0);
    checkOutput({tag, "_we"}, {31'd0, rf_we}, 32'h0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'h0);
    checkOutput({tag, "_fault"}, {31'd0, fault}, 32'h0);
    checkOutput({tag, "_fcode"}, {30'd0, fault_code}, 32'h0);
    checkOutput({tag, "_retired"}, retired, 32'h0);
  endtask

  task automatic waitFetch();
    int n = 0;
    while (imem_req !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    checkOutput("fetch_start", {31'd0, imem_req}, 32'd1);
  endtask

  // One full instruction pass starting from an observed FETCH cycle
  task automatic doInstr(input logic [31:0] instr, input int delay, input bit legal,
                         input logic [3:0] code, input bit drop_run);
    logic run_wb;
    checkOutput("fetch_addr", imem_addr, exp_pc);
    checkOutput("wrap_addr", imem_addr_w, exp_pc + WRAP_PC);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(run, 1'b0, 1'b0, $urandom);
      tick();
      checkOutput("fetch_wait_req", {31'd0, imem_req}, 32'd1);
    end
    applyStimulus(run, 1'b0, 1'b1, instr);
    tick();
    applyStimulus(drop_run ? 1'b0 : run, 1'b0, 1'b0, $urandom);
    run_wb = run;
    checkOutput("decode_ir", ir, instr);
    checkOutput("decode_req", {31'd0, imem_req}, 32'd0);
    checkOutput("decode_ra1", {27'd0, rf_ra1}, {27'd0, instr[19:15]});
    checkOutput("decode_ra2", {27'd0, rf_ra2}, {27'd0, instr[24:20]});
    checkOutput("decode_wa", {27'd0, rf_wa}, {27'd0, instr[11:7]});
    checkOutput("decode_we", {31'd0, rf_we}, 32'd0);
    tick();
    if (!legal) begin
      checkOutput("ill_fault", {31'd0, fault}, 32'd1);
      checkOutput("ill_code", {30'd0, fault_code}, 32'd2);
      checkOutput("ill_pc", pc, exp_pc);
      checkOutput("ill_retired", retired, exp_ret);
      checkOutput("ill_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("fault_sticky", {31'd0, fault}, 32'd1);
      checkOutput("fault_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(run_wb, 1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(run_wb, 1'b0, 1'b0, 32'h0);
      checkOutput("clr_fault", {31'd0, fault}, 32'd0);
      checkOutput("clr_code", {30'd0, fault_code}, 32'd0);
      checkOutput("clr_busy", {31'd0, busy}, 32'd0);
    end else begin
      checkOutput("exec_alu", {28'd0, alu_ctrl}, {28'd0, code});
      checkOutput("exec_we", {31'd0, rf_we}, 32'd0);
      checkOutput("exec_busy", {31'd0, busy}, 32'd1);
      tick();
      checkOutput("wb_we", {31'd0, rf_we}, {31'd0, (instr[11:7] != 5'd0)});
      checkOutput("wb_alu", {28'd0, alu_ctrl}, {28'd0, code});
      checkOutput("wb_pc", pc, exp_pc);
      tick();
      exp_pc  = exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      checkOutput("ret_pc", pc, exp_pc);
      checkOutput("ret_pc_wrap", pc_w, exp_pc + WRAP_PC);
      checkOutput("ret_count", retired, exp_ret);
      checkOutput("ret_next_req", {31'd0, imem_req}, {31'd0, run_wb});
      checkOutput("ret_next_busy", {31'd0, busy}, {31'd0, run_wb});
      checkOutput("ret_we_off", {31'd0, rf_we}, 32'd0);
    end
  endtask

  initial begin
    ops[0] = '{7'h00, 3'd0, 4'd0};
    ops[1] = '{7'h20, 3'd0, 4'd1};
    ops[2] = '{7'h00, 3'd1, 4'd2};
    ops[3] = '{7'h00, 3'd5, 4'd3};
    ops[4] = '{7'h20, 3'd5, 4'd4};
    ops[5] = '{7'h00, 3'd2, 4'd5};
    ops[6] = '{7'h00, 3'd3, 4'd6};
    ops[7] = '{7'h00, 3'd4, 4'd7};
    ops[8] = '{7'h00, 3'd6, 4'd8};
    ops[9] = '{7'h00, 3'd7, 4'd9};

    vecs[0]  = '{32'h407302B3, 0,  1'b1, 4'd1, 1'b0};
    vecs[1]  = '{32'h0020E1B3, 0,  1'b1, 4'd8, 1'b0};
    vecs[2]  = '{32'h0020F1B3, 0,  1'b1, 4'd9, 1'b0};
    vecs[3]  = '{32'h00208033, 0,  1'b1, 4'd0, 1'b0};
    vecs[4]  = '{32'h00000013, 0,  1'b0, 4'd0, 1'b0};
    vecs[5]  = '{32'h002091B3, 2,  1'b1, 4'd2, 1'b0};
    vecs[6]  = '{32'h0020D1B3, 1,  1'b1, 4'd3, 1'b0};
    vecs[7]  = '{32'h4020D1B3, 0,  1'b1, 4'd4, 1'b0};
    vecs[8]  = '{32'h0020A1B3, 3,  1'b1, 4'd5, 1'b0};
    vecs[9]  = '{32'h0020B1B3, 0,  1'b1, 4'd6, 1'b0};
    vecs[10] = '{32'h0020C1B3, 15, 1'b1, 4'd7, 1'b0};
    vecs[11] = '{32'h402091B3, 0,  1'b0, 4'd0, 1'b0};
    vecs[12] = '{32'h022081B3, 0,  1'b0, 4'd0, 1'b0};
    vecs[13] = '{32'h002081B3, 0,  1'b1, 4'd0, 1'b1};

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    reset   = 1'b1;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    #12;
    checkResetValues("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ack and clr_fault are ignored while idle
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    tick();
    checkOutput("idle_ack_ir", ir, 32'h0);
    checkOutput("idle_ack_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle_clr_fault", {31'd0, fault}, 32'd0);
    checkOutput("idle_clr_req", {31'd0, imem_req}, 32'd0);

    // First instruction: add x3,x1,x2 with immediate ack; wrap instance goes to 0
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitFetch();
    doInstr(32'h002081B3, 0, 1'b1, 4'd0, 1'b0);
    checkOutput("wrap_to_zero", pc_w, 32'h0);

    // Directed vector table
    for (int v = 0; v < 14; v++) begin
      if (run !== 1'b1) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      waitFetch();
      doInstr(vecs[v].instr, vecs[v].delay, vecs[v].legal, vecs[v].code, vecs[v].drop_run);
    end
    tick();
    checkOutput("drop_run_idle", {31'd0, busy}, 32'd0);

    // Fetch timeout: no ack for 16 FETCH cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitFetch();
    for (int k = 0; k < 16; k++) begin
      checkOutput("tmo_req", {31'd0, imem_req}, 32'd1);
      checkOutput("tmo_nofault", {31'd0, fault}, 32'd0);
      tick();
    end
    checkOutput("tmo_fault", {31'd0, fault}, 32'd1);
    checkOutput("tmo_code", {30'd0, fault_code}, 32'd1);
    checkOutput("tmo_req_drop", {31'd0, imem_req}, 32'd0);
    checkOutput("tmo_pc", pc, exp_pc);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h002081B3);
    tick();
    checkOutput("tmo_ack_ignored", {31'd0, fault}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("tmo_clr", {31'd0, fault}, 32'd0);
    checkOutput("tmo_clr_code", {30'd0, fault_code}, 32'd0);

    // Randomized instructions against the reference decode
    for (int r = 0; r < 40; r++) begin
      logic [31:0] instr;
      bit          legal;
      logic [3:0]  code;
      int          sel;
      if ($urandom_range(0, 3) != 0) begin
        sel   = $urandom_range(0, 9);
        instr = {ops[sel].f7, 5'($urandom), 5'($urandom), ops[sel].f3,
                 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 7'b0110011};
      end else begin
        instr = $urandom;
        if ($urandom_range(0, 1) == 1) instr[6:0] = 7'b0110011;
      end
      refDecode(instr, legal, code);
      if (run !== 1'b1) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      waitFetch();
      doInstr(instr, $urandom_range(0, 4), legal, code, ($urandom_range(0, 4) == 0));
    end

    // Asynchronous reset in EXEC
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    waitFetch();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h407302B3);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("pre_rst_alu", {28'd0, alu_ctrl}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkResetValues("rst_exec");
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Asynchronous reset in WB suppresses the write strobe at once
    waitFetch();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h002081B3);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("pre_rst_we", {31'd0, rf_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkResetValues("rst_wb");
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_mc_sequencer.md
Name: rv32_mc_sequencer

Overview:
- Multi-cycle sequencer for the RV32I R-type integer datapath.
- Fetches one instruction per pass over a req/ack instruction-memory port and checks legality using the team's R-type ALU encoding.
- Drives ALU control, register-file read/write addresses and the write strobe, advances the PC, and counts retired instructions.
- Sits between instruction memory and the register file + ALU; owns the PC and the instruction register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, cycles FETCH waits for imem_ack before faulting (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level: enables instruction execution.
- clr_fault  in  1  pulse: leaves FAULT and returns to IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  fetch data valid; sampled only while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  latched instruction register.
- alu_ctrl  out  4  ALU operation code.
- rf_ra1  out  5  rs1 address (= ir[19:15]).
- rf_ra2  out  5  rs2 address (= ir[24:20]).
- rf_wa  out  5  rd address (= ir[11:7]).
- rf_we  out  1  register-file write strobe.
- pc  out  32  current PC.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- fault  out  1  high in FAULT.
- fault_code  out  2  00 none, 01 fetch timeout, 10 illegal instruction.
- retired  out  32  retired-instruction count.

Behaviour:
- Reset (async, any state):
  - State -> IDLE; pc=RESET_PC.
  - ir=0, alu_ctrl=0, imem_req=0, rf_we=0, busy=0, fault=0, fault_code=00, retired=0, timeout counter=0.
- IDLE:
  - run=1 -> FETCH next edge; otherwise stay.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a cycle with imem_ack=1: ir<=imem_rdata, go to DECODE; imem_req low in the following cycle.
  - Each cycle without ack increments the timeout counter. At FETCH_TIMEOUT cycles without ack: go to FAULT, fault_code<=01.
  - Counter clears on entry to FETCH.
- DECODE (1 cycle):
  - Legal means ir[6:0]=0110011 and {ir[31:25],ir[14:12]} is one of: 0000000_000 ADD=0, 0100000_000 SUB=1, 0000000_001 SLL=2, 0000000_101 SRL=3, 0100000_101 SRA=4, 0000000_010 SLT=5, 0000000_011 SLTU=6, 0000000_100 XOR=7, 0000000_110 OR=8, 0000000_111 AND=9.
  - Legal: alu_ctrl<=code, go to EXEC.
  - Illegal: go to FAULT, fault_code<=10; alu_ctrl, pc and retired unchanged.
- EXEC (1 cycle): alu_ctrl held; go to WB.
- WB (1 cycle):
  - rf_we=1 iff rf_wa!=0. No write to x0; the instruction still retires.
  - pc<=pc+4, modulo 2^32 (FFFF_FFFC wraps to 0).
  - retired<=retired+1, wrapping.
  - Next state FETCH if run=1, else IDLE.
- rf_ra1, rf_ra2, rf_wa are continuous decodes of ir.
- alu_ctrl is valid in EXEC and WB.
- rf_we is high only in WB.
- Latency: an ack in the first FETCH cycle gives 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Back-to-back instructions occur with no idle cycle.
- run deasserted mid-instruction: the current instruction completes through WB, then the block goes to IDLE. run is sampled only in IDLE and WB.
- FAULT:
  - Sticky; fault=1, busy=0, imem_req=0, rf_we=0; pc points at the faulting instruction.
  - clr_fault=1 -> IDLE and fault_code<=00. run is ignored while in FAULT.
- clr_fault outside FAULT is ignored.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-WB: the register write is suppressed in the cycles reset is held; no partial pc or retired update.

Test Plan:
- Reset then run=1, imem_ack same cycle, rdata=0x002081B3 (add x3,x1,x2):
  - ir=0x002081B3; alu_ctrl=0 in EXEC.
  - rf_ra1=1, rf_ra2=2, rf_wa=3; rf_we pulses 1 cycle in WB 4 cycles after the first req.
  - pc=4, retired=1.
- rdata=0x407302B3 (sub x5,x6,x7) followed by the OR and AND encodings, run held high, ack immediate:
  - alu_ctrl sequence 1, 8, 9.
  - imem_req re-asserts the cycle after each WB; pc=0xC, retired=3.
- rdata=0x00208033 (rd=x0):
  - rf_we stays 0 throughout; pc advances by 4 and retired increments.
- rdata=0x00000013 (opcode 0010011):
  - FAULT, fault_code=10, pc unchanged, retired unchanged.
  - clr_fault pulse -> IDLE, fault=0.
- imem_ack never asserted, FETCH_TIMEOUT=16:
  - fault=1 and fault_code=01 after exactly 16 FETCH cycles; imem_req drops.
- RESET_PC=0xFFFF_FFFC with one legal instruction -> pc wraps to 0.
- Reset pulsed during EXEC -> all outputs at reset values immediately (asynchronous).
- run dropped during DECODE -> the instruction retires, then the block goes to IDLE with busy=0.
